// File: rtl/accelerator_vector_integration_pkg.sv
// Shared calculus package: default widths, FSM state encoding and stimulus selectors
// for the streaming vector integrator.
package accelerator_vector_integration_pkg;

   localparam int DATA_SIZE     = 64;
   localparam int CONTROL_SIZE  = 4;
   localparam int FRACTION_SIZE = 32;

   typedef enum logic [CONTROL_SIZE-1:0] {
      IDLE       = 4'd0,
      INPUT      = 4'd1,
      ACCUMULATE = 4'd2
   } state_t;

   localparam int STIMULUS_ACCELERATOR_VECTOR_INTEGRATION_BASIC      = 0;
   localparam int STIMULUS_ACCELERATOR_VECTOR_INTEGRATION_FRACTION   = 1;
   localparam int STIMULUS_ACCELERATOR_VECTOR_INTEGRATION_OVERFLOW   = 2;
   localparam int STIMULUS_ACCELERATOR_VECTOR_INTEGRATION_EMPTY      = 3;
   localparam int STIMULUS_ACCELERATOR_VECTOR_INTEGRATION_HANDSHAKE  = 4;
   localparam int STIMULUS_ACCELERATOR_VECTOR_INTEGRATION_RESET      = 5;

endpackage

// File: rtl/accelerator_vector_integration_multiplier.sv
// Combinational fixed-point scalar multiply: full signed product, floor shift by FRACTION_SIZE.
// ACCELERATOR_VECTOR_INTEGRATION_SATURATION_EN clamps the result instead of wrapping.
module accelerator_scalar_fixed_multiplier #(
   parameter int DATA_SIZE     = accelerator_vector_integration_pkg::DATA_SIZE,
   parameter int FRACTION_SIZE = accelerator_vector_integration_pkg::FRACTION_SIZE
) (
   input  logic signed [DATA_SIZE-1:0] i_a,
   input  logic signed [DATA_SIZE-1:0] i_b,
   output logic signed [DATA_SIZE-1:0] o_p
);

   logic signed [2*DATA_SIZE-1:0] w_product;
   logic signed [2*DATA_SIZE-1:0] w_shifted;

   assign w_product = i_a * i_b;
   assign w_shifted = w_product >>> FRACTION_SIZE;

`ifdef ACCELERATOR_VECTOR_INTEGRATION_SATURATION_EN
   // Result fits when every bit above the output sign bit matches it.
   logic w_fits;
   assign w_fits = (w_shifted[2*DATA_SIZE-1:DATA_SIZE-1] ==
                    {(DATA_SIZE+1){w_shifted[DATA_SIZE-1]}});

   always_comb begin
      if (w_fits)
         o_p = w_shifted[DATA_SIZE-1:0];
      else if (w_shifted[2*DATA_SIZE-1])
         o_p = {1'b1, {(DATA_SIZE-1){1'b0}}};
      else
         o_p = {1'b0, {(DATA_SIZE-1){1'b1}}};
   end
`else
   logic w_unused_high;
   assign w_unused_high = ^w_shifted[2*DATA_SIZE-1:DATA_SIZE];
   assign o_p = w_shifted[DATA_SIZE-1:0];
`endif

endmodule

// File: rtl/accelerator_vector_integration.sv
// Streaming integrator: y[i] = y[i-1] + ((x[i]*dt) >>> FRACTION_SIZE), one output per sample.
// ACCELERATOR_VECTOR_INTEGRATION_SATURATION_EN selects clamping instead of wrap-around.
module accelerator_vector_integration
   import accelerator_vector_integration_pkg::*;
#(
   parameter int DATA_SIZE     = accelerator_vector_integration_pkg::DATA_SIZE,
   parameter int FRACTION_SIZE = accelerator_vector_integration_pkg::FRACTION_SIZE
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   output logic                 READY,
   input  logic                 DATA_IN_ENABLE,
   output logic                 DATA_ENABLE,
   output logic                 DATA_OUT_ENABLE,
   input  logic [DATA_SIZE-1:0] SIZE_IN,
   input  logic [DATA_SIZE-1:0] LENGTH_IN,
   input  logic [DATA_SIZE-1:0] DATA_IN,
   output logic [DATA_SIZE-1:0] DATA_OUT
);

   localparam logic [DATA_SIZE-1:0] ONE = 1;

   state_t r_state, w_next_state;

   logic [DATA_SIZE-1:0] r_size, r_length, r_sample, r_acc, r_index, r_data_out;
   logic                 r_ready, r_data_out_enable;
   logic [DATA_SIZE-1:0] w_term, w_raw, w_sum, w_index_next;
   logic                 w_start, w_accept, w_accumulate, w_last;

   accelerator_scalar_fixed_multiplier #(
      .DATA_SIZE     (DATA_SIZE),
      .FRACTION_SIZE (FRACTION_SIZE)
   ) u_multiplier (
      .i_a (r_sample),
      .i_b (r_length),
      .o_p (w_term)
   );

   assign w_raw        = r_acc + w_term;
   assign w_index_next = r_index + ONE;
   assign w_last       = (w_index_next == r_size);

`ifdef ACCELERATOR_VECTOR_INTEGRATION_SATURATION_EN
   // Signed overflow: operands agree in sign but the sum does not.
   logic w_overflow;
   assign w_overflow = (r_acc[DATA_SIZE-1] == w_term[DATA_SIZE-1]) &&
                       (w_raw[DATA_SIZE-1] != r_acc[DATA_SIZE-1]);
   assign w_sum = !w_overflow        ? w_raw :
                  r_acc[DATA_SIZE-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}} :
                                       {1'b0, {(DATA_SIZE-1){1'b1}}};
`else
   assign w_sum = w_raw;
`endif

   always_ff @(posedge CLK) begin
      if (RST)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:       if (START && (SIZE_IN != '0)) w_next_state = INPUT;
         INPUT:      if (DATA_IN_ENABLE) w_next_state = ACCUMULATE;
         ACCUMULATE: w_next_state = w_last ? IDLE : INPUT;
         default:    w_next_state = IDLE;
      endcase
   end

   always_comb begin
      DATA_ENABLE  = (r_state == INPUT);
      w_start      = (r_state == IDLE) && START;
      w_accept     = (r_state == INPUT) && DATA_IN_ENABLE;
      w_accumulate = (r_state == ACCUMULATE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_size            <= '0;
         r_length          <= '0;
         r_sample          <= '0;
         r_acc             <= '0;
         r_index           <= '0;
         r_data_out        <= '0;
         r_ready           <= 1'b0;
         r_data_out_enable <= 1'b0;
      end else begin
         r_ready           <= 1'b0;
         r_data_out_enable <= 1'b0;
         if (w_start) begin
            r_size   <= SIZE_IN;
            r_length <= LENGTH_IN;
            r_acc    <= '0;
            r_index  <= '0;
            r_ready  <= (SIZE_IN == '0);
         end
         if (w_accept)
            r_sample <= DATA_IN;
         if (w_accumulate) begin
            r_acc             <= w_sum;
            r_data_out        <= w_sum;
            r_data_out_enable <= 1'b1;
            r_index           <= w_index_next;
            r_ready           <= w_last;
         end
      end
   end

   assign READY           = r_ready;
   assign DATA_OUT_ENABLE = r_data_out_enable;
   assign DATA_OUT        = r_data_out;

endmodule
